// File: rtl/br_pre_data_unpack256to64.sv
// Pre-data FIFO read-side unpacker: pops ceil(len/32) 256-bit words per descriptor
// and replays each word as up to four 64-bit valid/ready beats with sop/eop/mod.
module br_pre_data_unpack256to64 #(
  parameter int IN_WIDTH  = 256,
  parameter int OUT_WIDTH = 64,
  parameter int LEN_W     = 16
) (
  input  logic                 rdclk_i,
  input  logic                 aclr_i,
  input  logic                 len_valid_i,
  output logic                 len_ready_o,
  input  logic [LEN_W-1:0]     pkt_len_i,
  input  logic                 fifo_empty_i,
  output logic                 fifo_rdreq_o,
  input  logic [IN_WIDTH-1:0]  fifo_q_i,
  output logic [OUT_WIDTH-1:0] dout_o,
  output logic                 dout_valid_o,
  input  logic                 dout_ready_i,
  output logic                 dout_sop_o,
  output logic                 dout_eop_o,
  output logic [2:0]           dout_mod_o,
  output logic                 busy_o
);

  // state | meaning
  // IDLE  | waiting for a length descriptor
  // FETCH | waiting for a non-empty FIFO, then issues one read
  // LOAD  | FIFO word arrives, captured into the hold register
  // SEND  | presents lanes of the hold register as output beats
  typedef enum logic [1:0] {IDLE, FETCH, LOAD, SEND} state_t;

  state_t              state_q, state_d;
  logic [LEN_W-1:0]    rem_q, rem_d;
  logic                first_q, first_d;
  logic [1:0]          lane_q, lane_d;
  logic [IN_WIDTH-1:0] hold_q, hold_d;
  logic                eop;
  logic                xfer;

  always_ff @(posedge rdclk_i or posedge aclr_i) begin
    if (aclr_i) begin
      state_q <= IDLE;
      rem_q   <= '0;
      first_q <= 1'b0;
      lane_q  <= 2'd0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      first_q <= first_d;
      lane_q  <= lane_d;
      hold_q  <= hold_d;
    end
  end

  assign eop  = (state_q == SEND) && (rem_q <= LEN_W'(8));
  assign xfer = (state_q == SEND) && dout_ready_i;

  always_comb begin
    state_d      = state_q;
    rem_d        = rem_q;
    first_d      = first_q;
    lane_d       = lane_q;
    hold_d       = hold_q;
    fifo_rdreq_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (len_valid_i && pkt_len_i != '0) begin
          rem_d   = pkt_len_i;
          first_d = 1'b1;
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (!fifo_empty_i) begin
          fifo_rdreq_o = 1'b1;
          state_d      = LOAD;
        end
      end
      LOAD: begin
        hold_d  = fifo_q_i;
        lane_d  = 2'd0;
        state_d = SEND;
      end
      SEND: begin
        if (xfer) begin
          first_d = 1'b0;
          rem_d   = (rem_q > LEN_W'(8)) ? rem_q - LEN_W'(8) : '0;
          if (eop)                 state_d = IDLE;
          else if (lane_q == 2'd3) state_d = FETCH;
          else                     lane_d  = lane_q + 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign len_ready_o  = (state_q == IDLE);
  assign busy_o       = (state_q != IDLE);
  assign dout_valid_o = (state_q == SEND);
  assign dout_o       = (state_q == SEND) ? hold_q[OUT_WIDTH*lane_q +: OUT_WIDTH] : '0;
  assign dout_sop_o   = (state_q == SEND) && first_q;
  assign dout_eop_o   = eop;
  assign dout_mod_o   = eop ? rem_q[2:0] : 3'd0;

endmodule
